csr_test_monitor: RTL
=====================

CSR_TEST_MONITOR -- requirements
Module: csr_test_monitor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLE, default 100000: cycles in RUN before timeout is declared.
REQ-002 SHALL have parameter START_DELAY, default 10: cycles after reset release before CSR writes are honoured.
REQ-003 SHALL have parameter DRAIN_CYCLE, default 100: cycles held in DRAIN after a result is latched.
REQ-004 SHALL have parameter TOHOST_ADDR, default 12'h51E: CSR address that carries test status.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port csr_we, input, 1: the CPU commits a CSR write this cycle.
REQ-008 SHALL have port csr_addr, input, 12: address of the committed CSR write.
REQ-009 SHALL have port csr_wdata, input, 32: data of the committed CSR write.
REQ-010 SHALL have port cycle, output, 32: cycles elapsed since reset release, saturating.
REQ-011 SHALL have port result_cycle, output, 32: value of cycle latched at result or timeout.
REQ-012 SHALL have port pass, output, 1: tohost write of exactly 32'h1 was observed.
REQ-013 SHALL have port fail, output, 1: tohost write of a nonzero value other than 1 was observed.
REQ-014 SHALL have port timeout, output, 1: no qualifying write before TIMEOUT_CYCLE expired.
REQ-015 SHALL have port done, output, 1: monitor finished; testbench may end the simulation.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN and DONE; after reset the state is IDLE.
REQ-017 cycle SHALL increment by 1 every clock after reset release and SHALL saturate at 32'hFFFF_FFFF.
- In IDLE, a state counter counts START_DELAY cycles, then transitions to RUN.
- In IDLE, all CSR writes are ignored.
REQ-018 A qualifying write SHALL be csr_we=1 AND csr_addr=TOHOST_ADDR AND csr_wdata!=0; writes of 0 or to other addresses SHALL be ignored.
REQ-019 A qualifying write in RUN SHALL have the following effect on the next edge:
- pass=(csr_wdata==1); fail=!pass;
- result_cycle=cycle;
- state transitions to DRAIN.
REQ-020 In RUN, once the run counter reaches TIMEOUT_CYCLE-1 with no qualifying write, the next edge SHALL:
- set timeout=1;
- set result_cycle=cycle;
- transition directly to DONE (no drain).
REQ-021 A qualifying write in the same cycle the timeout condition is reached SHALL win: the result is latched, timeout stays 0, and the state goes to DRAIN.
REQ-022 DRAIN SHALL last exactly DRAIN_CYCLE cycles, then transition to DONE; qualifying writes in DRAIN or DONE SHALL be ignored, so the first result is sticky.
REQ-023 done SHALL be 1 only in DONE; DONE SHALL be terminal until reset.
REQ-024 pass, fail and timeout SHALL be mutually exclusive, and at most one of them SHALL ever be set per reset interval.
REQ-025 Outputs SHALL be registered; a qualifying write SHALL be visible on pass/fail exactly 1 cycle after the write cycle.
REQ-026 Counters SHALL be wide enough for the largest parameter; with DRAIN_CYCLE=0, the state SHALL go from DRAIN to DONE on the next edge.

Reset
REQ-027 On rst=0, the block SHALL immediately and asynchronously clear all of the following:
- state to IDLE;
- cycle and result_cycle to 0;
- pass, fail, timeout and done to 0;
- all internal counters to 0.
REQ-028 Reset asserted mid-RUN or mid-DRAIN SHALL discard any latched result; after release the block SHALL restart from IDLE.

Structure
REQ-029 The state encoding and the TOHOST_ADDR default SHALL live in the shared CPU package, alongside the existing CSR constants.
REQ-030 The block SHALL be a single module with no sub-modules; the two counters (cycle and state counter) are inline.

Verification
REQ-031 The bench SHALL cover these directed scenarios (START_DELAY=10, DRAIN_CYCLE=100 unless stated):
- Write 32'h1 to 0x51E at cycle 50 -> pass=1 at cycle 51, result_cycle=50, done=1 after 100 drain cycles, fail=timeout=0.
- Write 32'h3 to 0x51E -> fail=1, pass=0; a subsequent write of 32'h1 during DRAIN leaves fail=1.
- Write 0 to 0x51E, then 32'h1 to 0x340, then nothing, with TIMEOUT_CYCLE=200 -> timeout=1, done=1, pass=fail=0, no drain.
- Write 32'h1 at cycle 5 (inside IDLE), then nothing, with TIMEOUT_CYCLE=100 -> the write is ignored and timeout=1.
- Qualifying write coincident with the timeout cycle -> pass=1, timeout=0.
- Assert rst low mid-DRAIN -> all outputs 0 with no clock edge; after release the block restarts from IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: CSR addresses and test-monitor state encoding
package cpu_pkg;

  localparam logic [11:0] CSR_MSTATUS        = 12'h300;
  localparam logic [11:0] CSR_MTVEC          = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH       = 12'h340;
  localparam logic [11:0] CSR_MEPC           = 12'h341;
  localparam logic [11:0] CSR_MCAUSE         = 12'h342;
  localparam logic [11:0] CSR_TOHOST_DEFAULT = 12'h51E;

  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_RUN   = 2'd1,
    MON_DRAIN = 2'd2,
    MON_DONE  = 2'd3
  } mon_state_e;

endpackage

// File: rtl/csr_test_monitor.sv
// rtl/csr_test_monitor.sv - watches tohost CSR writes and reports pass/fail/timeout
module csr_test_monitor
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLE = 100000,
  parameter int unsigned START_DELAY   = 10,
  parameter int unsigned DRAIN_CYCLE   = 100,
  parameter logic [11:0] TOHOST_ADDR   = CSR_TOHOST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] cycle,
  output logic [31:0] result_cycle,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        done
);

  localparam int unsigned MAX_AB  = (TIMEOUT_CYCLE > START_DELAY) ? TIMEOUT_CYCLE : START_DELAY;
  localparam int unsigned CNT_MAX = (MAX_AB > DRAIN_CYCLE) ? MAX_AB : DRAIN_CYCLE;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(64'(CNT_MAX) + 64'd1);

  // One extra bit so the incremented count never wraps before the compare.
  typedef logic [CNT_W:0] cnt_ext_t;
  localparam cnt_ext_t START_LIM   = cnt_ext_t'(START_DELAY);
  localparam cnt_ext_t TIMEOUT_LIM = cnt_ext_t'(TIMEOUT_CYCLE);
  localparam cnt_ext_t DRAIN_LIM   = cnt_ext_t'(DRAIN_CYCLE);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      cycle_q, cycle_d;
  logic [31:0]      result_q, result_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;
  cnt_ext_t         cnt_inc;
  logic             qual;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    cnt_inc   = {1'b0, cnt_q} + cnt_ext_t'(1);
    qual      = csr_we && (csr_addr == TOHOST_ADDR) && (csr_wdata != 32'd0);
    cycle_d   = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;

    case (state_q)
      MON_IDLE: begin
        if (cnt_inc >= START_LIM) begin
          state_d = MON_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      MON_RUN: begin
        // A result written on the timeout cycle takes priority over the timeout.
        if (qual) begin
          pass_d   = (csr_wdata == 32'd1);
          fail_d   = (csr_wdata != 32'd1);
          result_d = cycle_q;
          state_d  = MON_DRAIN;
          cnt_d    = '0;
        end else if (cnt_inc >= TIMEOUT_LIM) begin
          timeout_d = 1'b1;
          result_d  = cycle_q;
          state_d   = MON_DONE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      MON_DRAIN: begin
        if (cnt_inc >= DRAIN_LIM) begin
          state_d = MON_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      MON_DONE: state_d = MON_DONE;
      default:  state_d = MON_IDLE;
    endcase

    done_d = (state_d == MON_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MON_IDLE;
      cnt_q     <= '0;
      cycle_q   <= '0;
      result_q  <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cycle_q   <= cycle_d;
      result_q  <= result_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  assign cycle        = cycle_q;
  assign result_cycle = result_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign done         = done_q;

endmodule
